psum_row_router_fifo: RTL and testbench

- Parametrised row-level partial-sum router for the PE array.
- Filters psum bus traffic by a configurable ID with a don't-care mask, enabling multicast to several PEs in a row.
- Buffers accepted psums in a small first-word-fall-through FIFO that the PE drains at its own pace.
- Counts psums per accumulation pass and emits a pass-done pulse. It sits between the row psum-in bus and one PE's psum input port.

---
 rtl/psum_row_router_fifo_if.sv | 14 +
 rtl/psum_row_router_fifo.sv | 147 ++++++++++++++
 tb/tb_psum_row_router_fifo.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_row_router_fifo_if.sv
// Row psum-in bus: destination ID and psum word with a valid/ready handshake.
// The bus drives the master side; each row router is a slave.
interface psum_row_router_fifo_if #(
    parameter int ID_WIDTH        = 8,
    parameter int PSUM_DATA_WIDTH = 48
);
    logic [ID_WIDTH-1:0]        bus_id;
    logic [PSUM_DATA_WIDTH-1:0] bus_data;
    logic                       bus_valid;
    logic                       bus_ready;

    modport master (output bus_id, output bus_data, output bus_valid, input bus_ready);
    modport slave  (input bus_id, input bus_data, input bus_valid, output bus_ready);
endinterface

// File: rtl/psum_row_router_fifo.sv
// Row-level psum router: ID/mask filter on the psum bus, FWFT FIFO towards one PE,
// and a per-pass accept counter that pulses pass_done once each pass has drained.
module psum_row_router_fifo #(
    parameter int PSUM_DATA_WIDTH = 48,
    parameter int ID_WIDTH        = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             config_state,
    input  logic                             ce,
    input  logic [ID_WIDTH-1:0]              cfg_id,
    input  logic [ID_WIDTH-1:0]              cfg_mask,
    input  logic [CNT_WIDTH-1:0]             cfg_count,
    psum_row_router_fifo_if.slave            bus,
    input  logic                             pe_psum_rd,
    output logic [PSUM_DATA_WIDTH-1:0]       pe_psum_out,
    output logic                             pe_psum_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             pass_done
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [1:0]                 state_next;
    logic [ID_WIDTH-1:0]        stored_id;
    logic [ID_WIDTH-1:0]        stored_mask;
    logic [CNT_WIDTH-1:0]       stored_count;
    logic [CNT_WIDTH-1:0]       acc_cnt;
    logic [CNT_WIDTH-1:0]       acc_inc;

    logic [PSUM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [PTR_WIDTH-1:0]       rd_ptr;
    logic [LVL_WIDTH-1:0]       level;
    logic [LVL_WIDTH-1:0]       level_next;

    logic match;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic pass_last;
    logic pass_end;

    // Masked bits (1) are don't-care, so one stored ID can address several PEs.
    assign match = ((bus.bus_id ^ stored_id) & ~stored_mask) == '0;
    assign full  = (level == LVL_WIDTH'(FIFO_DEPTH));
    assign empty = (level == '0);

    // Ready looks only at the registered level: a pop in the same cycle never
    // frees a slot for a push into a full FIFO.
    assign bus.bus_ready = (state == ST_RUN) && !config_state && match && !full;

    assign push      = bus.bus_valid && bus.bus_ready;
    assign pop       = pe_psum_rd && !empty;
    assign acc_inc   = acc_cnt + CNT_WIDTH'(1);
    assign pass_last = push && (acc_inc == stored_count);
    assign pass_end  = (state == ST_DRAIN) && (state_next == ST_RUN);

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_WIDTH'(1);
        end else if (pop && !push) begin
            level_next = level - LVL_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (config_state) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (stored_count != '0) state_next = ST_RUN;
                ST_RUN:   if (pass_last) state_next = ST_DRAIN;
                ST_DRAIN: if (level_next == '0) state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_id    <= '0;
            stored_mask  <= '0;
            stored_count <= '0;
        end else if (config_state && ce) begin
            stored_id    <= cfg_id;
            stored_mask  <= cfg_mask;
            stored_count <= cfg_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc_cnt   <= '0;
            pass_done <= 1'b0;
        end else begin
            state     <= state_next;
            pass_done <= pass_end;
            if (config_state || pass_end) begin
                acc_cnt <= '0;
            end else if (push) begin
                acc_cnt <= acc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (config_state) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            level <= level_next;
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible because
    // the output is gated by the level register, which is reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.bus_data;
    end

    assign pe_psum_valid = !empty;
    assign pe_psum_out   = empty ? '0 : mem[rd_ptr];
    assign fifo_level    = level;
endmodule

// File: tb/tb_psum_row_router_fifo.sv
// Bench for psum_row_router_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the router's pass/FIFO behaviour.
module tb_psum_row_router_fifo;
    localparam int DW    = 48;
    localparam int IW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           config_state;
    logic           ce;
    logic [IW-1:0]  cfg_id;
    logic [IW-1:0]  cfg_mask;
    logic [CW-1:0]  cfg_count;
    logic           pe_psum_rd;
    logic [DW-1:0]  pe_psum_out;
    logic           pe_psum_valid;
    logic [LW-1:0]  fifo_level;
    logic           pass_done;

    psum_row_router_fifo_if #(.ID_WIDTH(IW), .PSUM_DATA_WIDTH(DW)) bus_if ();

    psum_row_router_fifo #(
        .PSUM_DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .config_state(config_state), .ce(ce),
        .cfg_id(cfg_id), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
        .bus(bus_if), .pe_psum_rd(pe_psum_rd), .pe_psum_out(pe_psum_out),
        .pe_psum_valid(pe_psum_valid), .fifo_level(fifo_level), .pass_done(pass_done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: configuration, FIFO contents as a queue, pass bookkeeping.
    logic [IW-1:0] m_id;
    logic [IW-1:0] m_mask;
    int            m_count;
    logic [DW-1:0] m_q[$];
    int            m_acc;
    bit            m_active;
    bit            m_draining;
    bit            m_pd;

    function automatic bit id_matches(input logic [IW-1:0] id);
        for (int b = 0; b < IW; b++) begin
            if (!m_mask[b] && (id[b] != m_id[b])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_id = '0; m_mask = '0; m_count = 0;
        m_q.delete();
        m_acc = 0; m_active = 1'b0; m_draining = 1'b0; m_pd = 1'b0;
    endtask

    task automatic set_bus(input logic [IW-1:0] id, input logic [DW-1:0] d, input bit v, input bit rd);
        bus_if.bus_id    = id;
        bus_if.bus_data  = d;
        bus_if.bus_valid = v;
        pe_psum_rd       = rd;
    endtask

    // One clock cycle: compare all outputs with the model mid-cycle, then advance the model.
    task automatic tick(input string tag, output bit rdy, output bit popped, output logic [DW-1:0] pdata);
        bit            exp_rdy;
        bit            acc;
        bit            pop;
        logic [DW-1:0] exp_out;
        @(negedge clk);
        exp_out = (m_q.size() != 0) ? m_q[0] : '0;
        exp_rdy = m_active && !m_draining && !config_state && id_matches(bus_if.bus_id) && (m_q.size() < DEPTH);
        checks++;
        if (fifo_level !== LW'(m_q.size())) begin
            failures++;
            $display("FAIL %s level: got %0d expected %0d", tag, fifo_level, m_q.size());
        end
        checks++;
        if (pe_psum_valid !== (m_q.size() != 0)) begin
            failures++;
            $display("FAIL %s valid: got %b expected %b", tag, pe_psum_valid, m_q.size() != 0);
        end
        checks++;
        if (pe_psum_out !== exp_out) begin
            failures++;
            $display("FAIL %s out: got %h expected %h", tag, pe_psum_out, exp_out);
        end
        checks++;
        if (bus_if.bus_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s ready: got %b expected %b", tag, bus_if.bus_ready, exp_rdy);
        end
        checks++;
        if (pass_done !== m_pd) begin
            failures++;
            $display("FAIL %s pass_done: got %b expected %b", tag, pass_done, m_pd);
        end
        rdy    = bus_if.bus_ready;
        popped = pe_psum_rd && pe_psum_valid;
        pdata  = pe_psum_out;

        acc  = bus_if.bus_valid && exp_rdy;
        pop  = pe_psum_rd && (m_q.size() != 0);
        m_pd = 1'b0;
        if (config_state) begin
            m_q.delete();
            m_acc = 0; m_active = 1'b0; m_draining = 1'b0;
            if (ce) begin
                m_id = cfg_id; m_mask = cfg_mask; m_count = int'(cfg_count);
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(bus_if.bus_data);
            if (!m_active) begin
                m_active = (m_count != 0);
            end else if (!m_draining) begin
                if (acc) begin
                    m_acc++;
                    if (m_acc == m_count) m_draining = 1'b1;
                end
            end else if (m_q.size() == 0) begin
                m_draining = 1'b0; m_acc = 0; m_pd = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        bit r, p;
        logic [DW-1:0] d;
        tick(tag, r, p, d);
    endtask

    task automatic configure(input logic [IW-1:0] id, input logic [IW-1:0] mask, input int cnt);
        config_state = 1'b1; ce = 1'b1;
        cfg_id = id; cfg_mask = mask; cfg_count = CW'(cnt);
        set_bus('0, '0, 1'b0, 1'b0);
        step("cfg");
        config_state = 1'b0; ce = 1'b0;
        step("cfg_exit");
    endtask

    task automatic test_reset();
        bit r, p;
        logic [DW-1:0] d;
        rst_n = 1'b1; config_state = 1'b0; ce = 1'b0;
        cfg_id = '0; cfg_mask = '0; cfg_count = '0;
        set_bus('0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_level !== '0 || pe_psum_valid !== 1'b0 || pe_psum_out !== '0 ||
            bus_if.bus_ready !== 1'b0 || pass_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got level=%0d valid=%b out=%h ready=%b pd=%b expected all zero",
                     fifo_level, pe_psum_valid, pe_psum_out, bus_if.bus_ready, pass_done);
        end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        set_bus('0, 48'h1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("reset_idle", r, p, d);
            checks++;
            if (r !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_ready: got %b expected 0", r);
            end
        end
    endtask

    task automatic test_basic();
        logic [IW-1:0] ids [4] = '{8'h12, 8'h13, 8'h12, 8'h12};
        bit            exp_r [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [DW-1:0] exp_d [3] = '{48'd1, 48'd3, 48'd4};
        logic [DW-1:0] got[$];
        int pd_cnt = 0;
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h12, 8'h00, 3);
        for (int i = 0; i < 4; i++) begin
            set_bus(ids[i], DW'(i + 1), 1'b1, 1'b1);
            tick("basic", r, p, d);
            if (p) got.push_back(d);
            if (pass_done === 1'b1) pd_cnt++;
            checks++;
            if (r !== exp_r[i]) begin
                failures++;
                $display("FAIL basic_ready[%0d]: got %b expected %b", i, r, exp_r[i]);
            end
        end
        set_bus('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick("basic_drain", r, p, d);
            if (p) got.push_back(d);
            if (pass_done === 1'b1) pd_cnt++;
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL basic_count: got %0d words expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], exp_d[i]);
                end
            end
        end
        checks++;
        if (pd_cnt != 1) begin
            failures++;
            $display("FAIL basic_pass_done: got %0d pulses expected 1", pd_cnt);
        end
    endtask

    task automatic test_multicast();
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h10, 8'h03, 100);
        for (int i = 0; i < 8; i++) begin
            set_bus(IW'(8'h10 + i), DW'($urandom), 1'b1, 1'b1);
            tick("multicast", r, p, d);
            checks++;
            if (r !== (i < 4)) begin
                failures++;
                $display("FAIL multicast_ready id=%h: got %b expected %b", 8'h10 + i, r, i < 4);
            end
        end
        set_bus('0, '0, 1'b0, 1'b1);
        step("multicast_tail");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent [6];
        logic [DW-1:0] got[$];
        int w = 0;
        bit r, p;
        logic [DW-1:0] d;
        for (int i = 0; i < 6; i++) sent[i] = {16'hbeef, 32'($urandom)};
        configure(8'h21, 8'h00, 8);
        for (int i = 0; i < 5; i++) begin
            set_bus(8'h21, sent[w], 1'b1, 1'b0);
            tick("bp_fill", r, p, d);
            if (r) w++;
        end
        checks++;
        if (fifo_level !== LW'(4) || bus_if.bus_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got level=%0d ready=%b expected level=4 ready=0", fifo_level, bus_if.bus_ready);
        end
        set_bus(8'h21, sent[w], 1'b1, 1'b1);
        tick("bp_pop", r, p, d);
        if (p) got.push_back(d);
        checks++;
        if (r !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_pop_ready: got %b expected 0", r);
        end
        pe_psum_rd = 1'b0;
        checks++;
        if (fifo_level !== LW'(3) || bus_if.bus_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_after_pop: got level=%0d ready=%b expected level=3 ready=1", fifo_level, bus_if.bus_ready);
        end
        tick("bp_resume", r, p, d);
        if (r) w++;
        checks++;
        if (r !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume_accept: got %b expected 1", r);
        end
        for (int i = 0; i < 12; i++) begin
            set_bus(8'h21, (w < 6) ? sent[w] : '0, w < 6, 1'b1);
            tick("bp_drain", r, p, d);
            if (r && w < 6) w++;
            if (p) got.push_back(d);
        end
        checks++;
        if (got.size() != 6) begin
            failures++;
            $display("FAIL bp_count: got %0d words expected 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] got[$];
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h30, 8'h00, 50);
        for (int i = 0; i < 2; i++) begin
            set_bus(8'h30, DW'(100 + i), 1'b1, 1'b0);
            step("pp_fill");
        end
        set_bus(8'h30, DW'(102), 1'b1, 1'b1);
        tick("pp_both", r, p, d);
        if (p) got.push_back(d);
        checks++;
        if (fifo_level !== LW'(2)) begin
            failures++;
            $display("FAIL pp_level: got %0d expected 2", fifo_level);
        end
        set_bus('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("pp_drain", r, p, d);
            if (p) got.push_back(d);
        end
        tick("pp_empty_pop", r, p, d);
        checks++;
        if (fifo_level !== '0 || pe_psum_valid !== 1'b0 || pe_psum_out !== '0) begin
            failures++;
            $display("FAIL pp_underflow: got level=%0d valid=%b out=%h expected 0/0/0",
                     fifo_level, pe_psum_valid, pe_psum_out);
        end
        checks++;
        if (got.size() != 3 || got[0] !== DW'(100) || got[1] !== DW'(101) || got[2] !== DW'(102)) begin
            failures++;
            $display("FAIL pp_order: got %0d words expected 100,101,102", got.size());
        end
    endtask

    task automatic test_config_midpass();
        int pd_cnt = 0;
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h40, 8'h00, 10);
        for (int i = 0; i < 3; i++) begin
            set_bus(8'h40, DW'(i), 1'b1, 1'b0);
            step("cm_fill");
        end
        checks++;
        if (fifo_level !== LW'(3)) begin
            failures++;
            $display("FAIL cm_level3: got %0d expected 3", fifo_level);
        end
        config_state = 1'b1; ce = 1'b1; cfg_id = 8'h40; cfg_mask = 8'h00; cfg_count = CW'(2);
        tick("cm_cfg", r, p, d);
        checks++;
        if (r !== 1'b0) begin
            failures++;
            $display("FAIL cm_cfg_ready: got %b expected 0", r);
        end
        checks++;
        if (fifo_level !== '0 || bus_if.bus_ready !== 1'b0 || pass_done !== 1'b0) begin
            failures++;
            $display("FAIL cm_flush: got level=%0d ready=%b pd=%b expected 0/0/0", fifo_level, bus_if.bus_ready, pass_done);
        end
        config_state = 1'b0; ce = 1'b0;
        tick("cm_idle", r, p, d);
        for (int i = 0; i < 2; i++) begin
            set_bus(8'h40, DW'(50 + i), 1'b1, 1'b1);
            tick("cm_pass", r, p, d);
            if (pass_done === 1'b1) pd_cnt++;
        end
        set_bus('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick("cm_tail", r, p, d);
            if (pass_done === 1'b1) pd_cnt++;
        end
        checks++;
        if (pd_cnt != 1) begin
            failures++;
            $display("FAIL cm_new_count: got %0d pulses expected 1", pd_cnt);
        end
    endtask

    task automatic test_max_count();
        int pd_cnt = 0;
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h60, 8'h00, 255);
        for (int i = 0; i < 255; i++) begin
            set_bus(8'h60, DW'(i), 1'b1, 1'b1);
            tick("max_cnt", r, p, d);
            if (pass_done === 1'b1) pd_cnt++;
        end
        checks++;
        if (pd_cnt != 0) begin
            failures++;
            $display("FAIL max_early_done: got %0d pulses expected 0", pd_cnt);
        end
        set_bus('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick("max_tail", r, p, d);
            if (pass_done === 1'b1) pd_cnt++;
        end
        checks++;
        if (pd_cnt != 1) begin
            failures++;
            $display("FAIL max_done: got %0d pulses expected 1", pd_cnt);
        end
    endtask

    task automatic test_reset_drain();
        bit r, p;
        logic [DW-1:0] d;
        configure(8'h50, 8'h00, 2);
        for (int i = 0; i < 2; i++) begin
            set_bus(8'h50, DW'(7 + i), 1'b1, 1'b0);
            step("rd_fill");
        end
        set_bus(8'h50, '0, 1'b0, 1'b0);
        step("rd_drain");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_level !== '0 || pe_psum_valid !== 1'b0 || pe_psum_out !== '0 ||
            bus_if.bus_ready !== 1'b0 || pass_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got level=%0d valid=%b out=%h ready=%b pd=%b expected all zero",
                     fifo_level, pe_psum_valid, pe_psum_out, bus_if.bus_ready, pass_done);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        configure(8'h50, 8'h00, 0);
        set_bus(8'h50, DW'(9), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick("zero_count", r, p, d);
            checks++;
            if (r !== 1'b0 || pass_done !== 1'b0) begin
                failures++;
                $display("FAIL zero_count_idle: got ready=%b pd=%b expected 0/0", r, pass_done);
            end
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] id;
        configure(IW'($urandom), IW'($urandom) & 8'h05, 1 + int'($urandom_range(0, 9)));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                config_state = 1'b1; ce = 1'b1;
                cfg_id = IW'($urandom); cfg_mask = IW'($urandom) & 8'h0c;
                cfg_count = CW'($urandom_range(0, 12));
            end else begin
                config_state = 1'b0; ce = 1'b0;
            end
            if ($urandom_range(0, 3) != 0) id = (m_id & ~m_mask) | (IW'($urandom) & m_mask);
            else id = IW'($urandom);
            set_bus(id, {DW{1'b0}} | {16'($urandom), 32'($urandom)},
                    $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
            step("random");
        end
        config_state = 1'b0; ce = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_multicast();
        test_backpressure();
        test_push_pop();
        test_config_midpass();
        test_max_count();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
